// File: rtl/ppu_stream.sv
// ppu_stream: pixel processing unit between the byte source and scan-out.
// Input words are buffered in a FIFO. Each generated pixel is either a FIFO
// passthrough or derived procedurally from the pixel position, an animation
// counter and a FIFO-loaded seed.
module ppu_stream #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned CH_BITS  = 2,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned ANIM_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync,
  input  logic [2:0]           mode,
  input  logic [IN_W-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [3*CH_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eol
);

  localparam int unsigned PIX_W = 3 * CH_BITS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned XW    = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int unsigned YW    = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;
  localparam int unsigned DW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  // FIFO state
  logic [IN_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Position, animation and seed state
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [DW-1:0]    r_div;
  logic [7:0]       r_anim;
  logic [IN_W-1:0]  r_seed;

  // Output register
  logic             r_out_valid;
  logic [PIX_W-1:0] r_out_data;
  logic             r_out_sof;
  logic             r_out_eol;

  // Combinational control
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_slot;
  logic             w_gen;
  logic             w_origin;
  logic             w_seed_pop;
  logic             w_pop;
  logic [IN_W-1:0]  w_head;
  logic [IN_W-1:0]  w_seed_eff;
  logic             w_x_last;
  logic             w_y_last;
  logic             w_div_last;
  logic [9:0]       w_xa;
  logic [9:0]       w_ya;
  logic [9:0]       w_t;
  logic [PIX_W-1:0] w_pix;

  // Pixel rule for every mode; t is the 10-bit wrapped pattern term
  function automatic logic [PIX_W-1:0] f_pixel(
    input logic [2:0]      md,
    input logic [9:0]      px,
    input logic [9:0]      t,
    input logic [IN_W-1:0] word,
    input logic [IN_W-1:0] sd
  );
    logic [9:0]       m7;
    logic [9:0]       m11;
    logic [9:0]       sd10;
    logic [9:0]       u;
    logic [PIX_W-1:0] pix;
    m7   = t % 10'd7;
    m11  = t % 10'd11;
    sd10 = 10'(sd);
    u    = (m7 | m11) ^ sd10;
    pix  = '0;
    case (md)
      3'd0:    pix = word[IN_W-1 -: PIX_W];
      3'd1:    pix = {{CH_BITS{px[5]}}, {CH_BITS{px[6]}}, {CH_BITS{px[7]}}};
      3'd2:    pix = (m7 == '0) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      3'd3:    pix = {{CH_BITS{u[0]}}, {CH_BITS{u[2]}}, {CH_BITS{u[4]}}};
      3'd4:    pix = sd[IN_W-1 -: PIX_W];
      3'd5:    pix = {3{px[9 -: CH_BITS]}};
      default: pix = '0;
    endcase
    return pix;
  endfunction

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rd_ptr];

  assign w_slot     = !r_out_valid || out_ready;
  assign w_gen      = w_slot && ((mode != 3'd0) || !w_empty);
  assign w_origin   = (r_x == '0) && (r_y == '0);
  assign w_seed_pop = w_gen && (mode >= 3'd2) && w_origin && !w_empty;
  assign w_pop      = (w_gen && (mode == 3'd0)) || w_seed_pop;
  // The origin pixel must already see the word popped into the seed this
  // cycle, so the FIFO head bypasses the seed register on that beat.
  assign w_seed_eff = w_seed_pop ? w_head : r_seed;

  assign w_x_last   = (r_x == XW'(H_TOTAL - 1));
  assign w_y_last   = (r_y == YW'(V_TOTAL - 1));
  assign w_div_last = (r_div == DW'(ANIM_DIV - 1));

  assign w_xa  = r_x[9:0] + {2'b00, r_anim};
  assign w_ya  = r_y[9:0] + {2'b00, r_anim};
  assign w_t   = w_xa ^ w_ya;
  assign w_pix = f_pixel(mode, r_x[9:0], w_t, w_head, w_seed_eff);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sof   = r_out_sof;
  assign out_eol   = r_out_eol;

  // FIFO storage; occupancy qualifies every read so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Position tracking; sync wins over advancement so the next pixel is (0,0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_div <= '0;
    end else if (sync) begin
      r_x   <= '0;
      r_y   <= '0;
      r_div <= '0;
    end else if (w_gen) begin
      if (w_x_last) begin
        r_x <= '0;
        if (w_y_last) begin
          r_y <= '0;
          r_div <= w_div_last ? '0 : r_div + DW'(1);
        end else begin
          r_y <= r_y + YW'(1);
        end
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  // Animation step once every ANIM_DIV completed frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_anim <= '0;
    end else if (w_gen && w_x_last && w_y_last && w_div_last) begin
      r_anim <= r_anim + 8'd1;
    end
  end

  // Seed capture at the frame origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seed <= '0;
    end else if (w_seed_pop) begin
      r_seed <= w_head;
    end
  end

  // Output register: load on generation, drop valid on an empty open slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
    end else if (w_gen) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_pix;
      r_out_sof   <= w_origin;
      r_out_eol   <= w_x_last;
    end else if (w_slot) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppu_stream.sv
// Self-checking bench for ppu_stream: directed scenarios with hand-computed
// expectations plus a long randomized run compared every cycle against a
// behavioural model built from queues and plain arithmetic.
module tb_ppu_stream;

  localparam int IN_W     = 8;
  localparam int CH_BITS  = 2;
  localparam int DEPTH    = 32;
  localparam int H_TOTAL  = 600;
  localparam int V_TOTAL  = 4;
  localparam int ANIM_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_sof;
  logic       out_eol;

  ppu_stream #(
    .IN_W(IN_W),
    .CH_BITS(CH_BITS),
    .DEPTH(DEPTH),
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL),
    .ANIM_DIV(ANIM_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sync(sync),
    .mode(mode),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sof(out_sof),
    .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int q[$];
  int mx = 0, my = 0, mdiv = 0, manim = 0, mseed = 0, m_data = 0;
  bit m_valid = 0, m_sof = 0, m_eol = 0;

  function automatic int chan(int b);
    return (b != 0) ? 3 : 0;
  endfunction

  function automatic int rgb(int r, int g, int b);
    return chan(r) * 16 + chan(g) * 4 + chan(b);
  endfunction

  function automatic int model_pixel(int md, int x, int y, int an, int sd, int word);
    int t, u, c;
    t = ((x + an) % 1024) ^ ((y + an) % 1024);
    u = ((t % 7) | (t % 11)) ^ sd;
    c = (x / 256) % 4;
    case (md)
      0:       return (word / 4) % 64;
      1:       return rgb((x / 32) % 2, (x / 64) % 2, (x / 128) % 2);
      2:       return (t % 7 == 0) ? 63 : 0;
      3:       return rgb(u % 2, (u / 4) % 2, (u / 16) % 2);
      4:       return (sd / 4) % 64;
      5:       return c * 21;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin : model_step
    bit open_s, gen, spop, pop, push, ne;
    int head, sd;
    if (rst) begin
      q.delete();
      mx = 0; my = 0; mdiv = 0; manim = 0; mseed = 0;
      m_valid = 0; m_data = 0; m_sof = 0; m_eol = 0;
    end else begin
      ne     = (q.size() != 0);
      head   = ne ? q[0] : 0;
      open_s = !m_valid || out_ready;
      gen    = open_s && (mode != 0 || ne);
      spop   = gen && mode >= 2 && mx == 0 && my == 0 && ne;
      pop    = (gen && mode == 0) || spop;
      push   = in_valid && (q.size() < DEPTH);
      sd     = spop ? head : mseed;
      if (gen) begin
        m_data  = model_pixel(int'(mode), mx, my, manim, sd, head);
        m_sof   = (mx == 0 && my == 0);
        m_eol   = (mx == H_TOTAL - 1);
        m_valid = 1;
      end else if (open_s) begin
        m_valid = 0;
      end
      mseed = sd;
      if (gen && mx == H_TOTAL - 1 && my == V_TOTAL - 1 && mdiv == ANIM_DIV - 1)
        manim = (manim + 1) % 256;
      if (sync) begin
        mx = 0; my = 0; mdiv = 0;
      end else if (gen) begin
        mx++;
        if (mx == H_TOTAL) begin
          mx = 0;
          my++;
          if (my == V_TOTAL) begin
            my = 0;
            mdiv = (mdiv + 1) % ANIM_DIV;
          end
        end
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(int'(in_data));
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("in_ready", int'(in_ready), (q.size() < DEPTH) ? 1 : 0);
      if (m_valid) begin
        chk("out_data", int'(out_data), m_data);
        chk("out_sof", int'(out_sof), int'(m_sof));
        chk("out_eol", int'(out_eol), int'(m_eol));
      end
    end
  end

  // ---------------- stimulus and directed checks ----------------
  initial begin
    int unsigned words[33];
    int eolcnt;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sof", int'(out_sof), 0);
    chk("rst_out_eol", int'(out_eol), 0);
    rst = 1'b0;

    // passthrough
    repeat (2) @(negedge clk);
    chk("m0_empty_valid", int'(out_valid), 0);
    in_valid = 1'b1; in_data = 8'hE4;
    @(negedge clk);
    chk("m0_latency_valid", int'(out_valid), 0);
    in_data = 8'h1B;
    @(negedge clk);
    chk("pt0_valid", int'(out_valid), 1);
    chk("pt0_data", int'(out_data), 'h39);
    chk("pt0_sof", int'(out_sof), 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pt1_data", int'(out_data), 'h06);
    chk("pt1_sof", int'(out_sof), 0);
    @(negedge clk);
    chk("pt_drained_valid", int'(out_valid), 0);

    // seed: hold one pixel, restart position, load 0xFC then 0x00
    mode = 3'd4; out_ready = 1'b0; sync = 1'b1;
    @(negedge clk);
    sync = 1'b0; in_valid = 1'b1; in_data = 8'hFC;
    @(negedge clk);
    in_data = 8'h00;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("seed_origin_data", int'(out_data), 'h3F);
    chk("seed_origin_sof", int'(out_sof), 1);
    @(negedge clk);
    chk("seed_next_data", int'(out_data), 'h3F);
    chk("seed_next_sof", int'(out_sof), 0);

    // back-pressure in checker mode
    mode = 3'd2; sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    @(negedge clk);
    chk("bp_origin_data", int'(out_data), 'h3F);
    chk("bp_origin_sof", int'(out_sof), 1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_data", int'(out_data), 'h3F);
      chk("bp_hold_sof", int'(out_sof), 1);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("bp_run_data", int'(out_data), (k == 7) ? 'h3F : 0);
      chk("bp_run_sof", int'(out_sof), 0);
    end

    // FIFO full: 33 pushes with no pops, then drain in mode 0
    mode = 3'd6; out_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      words[i] = $urandom_range(0, 255);
      in_valid = 1'b1;
      in_data  = 8'(words[i]);
      @(negedge clk);
      if (i == 30) chk("fifo_ready_at_31", int'(in_ready), 1);
      else if (i >= 31) chk("fifo_full_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; mode = 3'd0; out_ready = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk);
      if (i < 32) begin
        chk("drain_valid", int'(out_valid), 1);
        chk("drain_data", int'(out_data), int'((words[i] / 4) % 64));
      end else begin
        chk("drain_end_valid", int'(out_valid), 0);
      end
    end

    // sync at x=100 in stripe mode
    mode = 3'd1; sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    for (int k = 0; k < 100; k++) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    chk("sync_x100_data", int'(out_data), 'h3C);
    chk("sync_x100_sof", int'(out_sof), 0);
    sync = 1'b0;
    @(negedge clk);
    chk("sync_next_sof", int'(out_sof), 1);
    chk("sync_next_data", int'(out_data), 0);

    // asynchronous reset with a full FIFO and a held pixel
    mode = 3'd6; out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre_rst_ready", int'(in_ready), 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", int'(out_valid), 0);
    chk("rst_async_ready", int'(in_ready), 1);
    mode = 3'd2; out_ready = 1'b1; sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // two full frames in checker mode: frame wrap and animation step
    eolcnt = 0;
    for (int n = 0; n <= 4805; n++) begin
      @(negedge clk);
      eolcnt += int'(out_eol);
      if (n == 0) begin
        chk("proc_latency_valid", int'(out_valid), 1);
        chk("proc_first_sof", int'(out_sof), 1);
        chk("proc_first_data", int'(out_data), 'h3F);
      end
      if (n == 5)    chk("anim0_x5_data", int'(out_data), 0);
      if (n == 2405) chk("frame2_x5_data", int'(out_data), 0);
      if (n == 4800) begin
        chk("anim1_origin_data", int'(out_data), 'h3F);
        chk("anim1_origin_sof", int'(out_sof), 1);
      end
      if (n == 4805) chk("anim1_x5_data", int'(out_data), 'h3F);
    end
    chk("eol_count", eolcnt, 8);

    // randomized traffic against the model
    for (int c = 0; c < 30000; c++) begin
      if ($urandom_range(0, 199) == 0) mode = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      sync      = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
    end
    sync = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
